seq_burst_arbiter: RTL and testbench

Shares one 3-bit pseudo-random sequence source between two requesters. The source steps through the fixed cycle 7,4,1,6,2,5, then repeats from 7. A requester wins a grant and receives a burst of BURST_LEN values over a valid/ready stream; grants rotate round-robin. The block sits between the sequence-generator datapath and its consumers (test-pattern and scrambler users).

---
 rtl/seq_burst_arbiter_pkg.sv | 30 +++
 rtl/seq_burst_arbiter_if.sv | 24 ++
 rtl/seq_burst_arbiter_seq_src_step.sv | 36 +++
 rtl/seq_burst_arbiter.sv | 122 ++++++++++++
 tb/tb_seq_burst_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_burst_arbiter_pkg.sv
// Shared definitions for the sequence burst arbiter: FSM state encoding,
// the six legal sequence values and the sequence step function.
package seq_pkg;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   localparam logic [2:0] SEQ_7 = 3'd7;
   localparam logic [2:0] SEQ_4 = 3'd4;
   localparam logic [2:0] SEQ_1 = 3'd1;
   localparam logic [2:0] SEQ_6 = 3'd6;
   localparam logic [2:0] SEQ_2 = 3'd2;
   localparam logic [2:0] SEQ_5 = 3'd5;

   // Steps 7->4->1->6->2->5->7; the unused codes 0 and 3 recover to 7.
   function automatic logic [2:0] seq_next(input logic [2:0] cur);
      case (cur)
         SEQ_7:   seq_next = SEQ_4;
         SEQ_4:   seq_next = SEQ_1;
         SEQ_1:   seq_next = SEQ_6;
         SEQ_6:   seq_next = SEQ_2;
         SEQ_2:   seq_next = SEQ_5;
         SEQ_5:   seq_next = SEQ_7;
         default: seq_next = SEQ_7;
      endcase
   endfunction

endpackage

// File: rtl/seq_burst_arbiter_if.sv
// Request/grant and valid/ready stream bundle between the arbiter and its
// two requesters. The arbiter uses the master side.
interface seq_burst_arbiter_if;

   logic [1:0] req;
   logic [1:0] gnt;
   logic       seq_valid;
   logic [2:0] seq_data;
   logic       seq_ready;
   logic       seq_owner;
   logic       burst_done;
   logic       busy;

   modport master (
      input  req, seq_ready,
      output gnt, seq_valid, seq_data, seq_owner, burst_done, busy
   );

   modport slave (
      output req, seq_ready,
      input  gnt, seq_valid, seq_data, seq_owner, burst_done, busy
   );

endinterface

// File: rtl/seq_burst_arbiter_seq_src_step.sv
// Three-bit sequence register: holds the current sequence value and steps
// it once per accepted transfer. Loads SEED on reset.
module seq_src_step
   import seq_pkg::*;
#(
   parameter logic [2:0] SEED = SEQ_7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
   output logic [2:0] value
);

   logic [2:0] value_d;
   logic [2:0] value_q;

   // Next value: step only when a transfer is accepted, otherwise hold.
   always_comb begin
      value_d = value_q;
      if (advance) begin
         value_d = seq_next(value_q);
      end
   end

   // Sequence state register with synchronous reload of the seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= SEED;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/seq_burst_arbiter.sv
// Round-robin burst arbiter: grants one of two requesters a burst of
// BURST_LEN sequence values over a valid/ready stream. All outputs are
// registered; the sequence continues across bursts.
module seq_burst_arbiter
   import seq_pkg::*;
#(
   parameter int         BURST_LEN = 4,
   parameter logic [2:0] SEED      = SEQ_7
) (
   input logic                  clk,
   input logic                  rst,
   seq_burst_arbiter_if.master  bus
);

   localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

   state_t     state_d, state_q;
   logic [1:0] gnt_d, gnt_q;
   logic       seq_valid_d, seq_valid_q;
   logic       busy_d, busy_q;
   logic       burst_done_d, burst_done_q;
   logic       seq_owner_d, seq_owner_q;
   logic       ptr_d, ptr_q;
   logic [3:0] count_d, count_q;

   logic       handshake;
   logic       owner_req;
   logic       winner;
   logic [2:0] seq_value;

   assign handshake = seq_valid_q & bus.seq_ready;
   assign owner_req = bus.req[seq_owner_q];

   seq_src_step #(
      .SEED (SEED)
   ) u_src (
      .clk     (clk),
      .rst     (rst),
      .advance (handshake),
      .value   (seq_value)
   );

   // Next-state logic: pick a winner in IDLE, count beats in STREAM and
   // leave on completion or when the owner withdraws its request.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      seq_valid_d  = seq_valid_q;
      busy_d       = busy_q;
      burst_done_d = 1'b0;
      seq_owner_d  = seq_owner_q;
      ptr_d        = ptr_q;
      count_d      = count_q;
      winner       = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req != 2'b00) begin
               winner      = bus.req[ptr_q] ? ptr_q : ~ptr_q;
               state_d     = S_STREAM;
               gnt_d       = winner ? 2'b10 : 2'b01;
               seq_owner_d = winner;
               seq_valid_d = 1'b1;
               busy_d      = 1'b1;
               count_d     = 4'd0;
            end
         end
         S_STREAM: begin
            if (handshake) begin
               count_d = count_q + 4'd1;
            end
            if (handshake && (count_q == LAST_BEAT)) begin
               state_d      = S_IDLE;
               gnt_d        = 2'b00;
               seq_valid_d  = 1'b0;
               busy_d       = 1'b0;
               burst_done_d = 1'b1;
               ptr_d        = ~seq_owner_q;
            end else if (!owner_req) begin
               state_d     = S_IDLE;
               gnt_d       = 2'b00;
               seq_valid_d = 1'b0;
               busy_d      = 1'b0;
               ptr_d       = ~seq_owner_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered FSM state and outputs; reset aborts any burst silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         gnt_q        <= 2'b00;
         seq_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         burst_done_q <= 1'b0;
         seq_owner_q  <= 1'b0;
         ptr_q        <= 1'b0;
         count_q      <= 4'd0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         seq_valid_q  <= seq_valid_d;
         busy_q       <= busy_d;
         burst_done_q <= burst_done_d;
         seq_owner_q  <= seq_owner_d;
         ptr_q        <= ptr_d;
         count_q      <= count_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.seq_valid  = seq_valid_q;
   assign bus.seq_data   = seq_value;
   assign bus.seq_owner  = seq_owner_q;
   assign bus.burst_done = burst_done_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_seq_burst_arbiter.sv
// Bench for seq_burst_arbiter: two instances (BURST_LEN 4 and 1) share
// stimulus; a transaction-level model predicts every output each cycle.
module tb_seq_burst_arbiter;

   logic clk;
   logic rst;

   seq_burst_arbiter_if bus ();
   seq_burst_arbiter_if bus1 ();

   assign bus1.req       = bus.req;
   assign bus1.seq_ready = bus.seq_ready;

   seq_burst_arbiter #(.BURST_LEN(4), .SEED(3'd7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   seq_burst_arbiter #(.BURST_LEN(1), .SEED(3'd7)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   int         vectorCount;
   int         missCount;
   logic [2:0] acceptedQ[$];

   int         mOwner[2];
   int         mBeats[2];
   int         mPtr[2];
   logic [2:0] mSeq[2];
   logic       mDone[2];
   int         mLen[2];

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [2:0] seqAfter(input logic [2:0] cur);
      logic [2:0] order[6];
      order = '{3'd7, 3'd4, 3'd1, 3'd6, 3'd2, 3'd5};
      for (int i = 0; i < 6; i++) begin
         if (order[i] == cur) return order[(i + 1) % 6];
      end
      return 3'd7;
   endfunction

   task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vectorCount++;
      assert (obs === expv) else begin
         missCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic modelStep(input logic [1:0] r, input logic rdy, input logic rs);
      for (int k = 0; k < 2; k++) begin
         if (rs) begin
            mOwner[k] = -1;
            mBeats[k] = 0;
            mPtr[k]   = 0;
            mSeq[k]   = 3'd7;
            mDone[k]  = 1'b0;
         end else begin
            mDone[k] = 1'b0;
            if (mOwner[k] < 0) begin
               if (r != 2'b00) begin
                  mOwner[k] = r[mPtr[k]] ? mPtr[k] : 1 - mPtr[k];
                  mBeats[k] = 0;
               end
            end else begin
               if (rdy) begin
                  mSeq[k] = seqAfter(mSeq[k]);
                  mBeats[k]++;
               end
               if (rdy && mBeats[k] == mLen[k]) begin
                  mDone[k]  = 1'b1;
                  mPtr[k]   = 1 - mOwner[k];
                  mOwner[k] = -1;
               end else if (!r[mOwner[k]]) begin
                  mPtr[k]   = 1 - mOwner[k];
                  mOwner[k] = -1;
               end
            end
         end
      end
   endtask

   task automatic checkInst(input int k, input logic [1:0] g, input logic v,
                            input logic [2:0] d, input logic o,
                            input logic dn, input logic b);
      logic [1:0] expGnt;
      logic       active;
      active = (mOwner[k] >= 0);
      expGnt = !active ? 2'b00 : (mOwner[k] == 0 ? 2'b01 : 2'b10);
      checkEq($sformatf("gnt%0d", k), 8'(g), 8'(expGnt));
      checkEq($sformatf("seq_valid%0d", k), 8'(v), 8'(active));
      checkEq($sformatf("busy%0d", k), 8'(b), 8'(active));
      checkEq($sformatf("burst_done%0d", k), 8'(dn), 8'(mDone[k]));
      if (active) begin
         checkEq($sformatf("seq_data%0d", k), 8'(d), 8'(mSeq[k]));
         checkEq($sformatf("seq_owner%0d", k), 8'(o), 8'(mOwner[k]));
      end
   endtask

   task automatic checkOutput();
      checkInst(0, bus.gnt, bus.seq_valid, bus.seq_data, bus.seq_owner,
                bus.burst_done, bus.busy);
      checkInst(1, bus1.gnt, bus1.seq_valid, bus1.seq_data, bus1.seq_owner,
                bus1.burst_done, bus1.busy);
   endtask

   // Called just after a falling edge: drive, clock, update model, check.
   task automatic applyStimulus(input logic [1:0] r, input logic rdy, input logic rs);
      bus.req       = r;
      bus.seq_ready = rdy;
      rst           = rs;
      if (!rs && bus.seq_valid === 1'b1 && rdy) acceptedQ.push_back(bus.seq_data);
      @(posedge clk);
      modelStep(r, rdy, rs);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic checkBurst(input string tag, input int offset, input logic [2:0] expv[4]);
      for (int i = 0; i < 4; i++) begin
         checkEq($sformatf("%s_beat%0d", tag, i), 8'(acceptedQ[offset + i]), 8'(expv[i]));
      end
   endtask

   // Directed scenarios followed by a randomized run.
   initial begin
      logic [2:0] badVals[2];
      vectorCount   = 0;
      missCount     = 0;
      mLen          = '{4, 1};
      rst           = 1'b1;
      bus.req       = 2'b00;
      bus.seq_ready = 1'b0;
      badVals       = '{3'd3, 3'd0};
      @(negedge clk);

      $display("[TB] reset");
      applyStimulus(2'b00, 1'b0, 1'b1);
      applyStimulus(2'b11, 1'b1, 1'b1);

      $display("[TB] single burst to requester 0");
      acceptedQ.delete();
      repeat (5) applyStimulus(2'b01, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkEq("first_count", 8'(acceptedQ.size()), 8'd4);
      checkBurst("first", 0, '{3'd7, 3'd4, 3'd1, 3'd6});

      $display("[TB] both requesting, round robin");
      acceptedQ.delete();
      repeat (15) applyStimulus(2'b11, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkEq("rr_count", 8'(acceptedQ.size()), 8'd12);
      checkBurst("rr_a", 0, '{3'd2, 3'd5, 3'd7, 3'd4});
      checkBurst("rr_b", 4, '{3'd1, 3'd6, 3'd2, 3'd5});
      checkBurst("rr_c", 8, '{3'd7, 3'd4, 3'd1, 3'd6});

      $display("[TB] stalled stream");
      acceptedQ.delete();
      applyStimulus(2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(2'b01, (i % 3) == 0, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkEq("stall_count", 8'(acceptedQ.size()), 8'd4);
      checkBurst("stall", 0, '{3'd2, 3'd5, 3'd7, 3'd4});

      $display("[TB] abort by request drop");
      acceptedQ.delete();
      applyStimulus(2'b01, 1'b0, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b0);
      checkEq("abort_ptr_gnt", 8'(bus.gnt), 8'(2'b10));
      repeat (4) applyStimulus(2'b11, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkEq("abort_count", 8'(acceptedQ.size()), 8'd6);
      checkEq("abort_v0", 8'(acceptedQ[0]), 8'd1);
      checkEq("abort_v1", 8'(acceptedQ[1]), 8'd6);
      checkBurst("after_abort", 2, '{3'd2, 3'd5, 3'd7, 3'd4});

      $display("[TB] request drop together with handshake");
      applyStimulus(2'b01, 1'b0, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      applyStimulus(2'b01, 1'b0, 1'b0);
      repeat (3) applyStimulus(2'b01, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);

      $display("[TB] reset in mid-burst");
      applyStimulus(2'b01, 1'b0, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b1);
      acceptedQ.delete();
      repeat (5) applyStimulus(2'b01, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkEq("post_rst_count", 8'(acceptedQ.size()), 8'd4);
      checkBurst("post_rst", 0, '{3'd7, 3'd4, 3'd1, 3'd6});

      $display("[TB] illegal sequence state recovery");
      for (int j = 0; j < 2; j++) begin
         applyStimulus(2'b00, 1'b0, 1'b1);
         applyStimulus(2'b01, 1'b0, 1'b0);
         force dut.u_src.value_q = badVals[j];
         #1;
         checkEq($sformatf("illegal_hold%0d", j), 8'(bus.seq_data), 8'(badVals[j]));
         release dut.u_src.value_q;
         mSeq[0] = badVals[j];
         applyStimulus(2'b01, 1'b1, 1'b0);
         checkEq($sformatf("illegal_recover%0d", j), 8'(bus.seq_data), 8'd7);
         repeat (3) applyStimulus(2'b01, 1'b1, 1'b0);
         applyStimulus(2'b00, 1'b0, 1'b0);
      end

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 63) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
